// File: rtl/layer5_argmax.sv
// rtl/layer5_argmax.sv - streaming argmax over one frame of signed logits, valid/ready result
// Optional second-best index and margin outputs: define ARGMAX_TOP2_EN.
module layer5_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [IDX_WIDTH-1:0]  class_idx,
    output logic signed [DATA_WIDTH-1:0] max_score,
    output logic                         frame_err,
`ifdef ARGMAX_TOP2_EN
    output logic        [IDX_WIDTH-1:0]  second_idx,
    output logic        [DATA_WIDTH:0]   margin,
`endif
    output logic        [CNT_WIDTH-1:0]  img_count
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                       state_q, state_d;
    logic        [IDX_WIDTH-1:0]  cnt_q;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic        [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
    logic        [IDX_WIDTH-1:0]  class_idx_q;
    logic signed [DATA_WIDTH-1:0] max_score_q;
    logic                         frame_err_q;
    logic        [CNT_WIDTH-1:0]  img_count_q;

    logic beat, first, at_last, term, err, gt, handshake;

    assign beat      = valid_in && (state_q == ACCUM);
    assign first     = (cnt_q == '0);
    assign at_last   = (cnt_q == LAST_IDX);
    assign term      = in_last || at_last;
    assign err       = in_last != at_last;
    assign gt        = in_data > best_q;
    assign handshake = (state_q == HOLD) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (beat && term) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (first || gt) begin
            best_d     = in_data;
            best_idx_d = first ? '0 : cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
            frame_err_q <= 1'b0;
            img_count_q <= '0;
        end else begin
            if (beat) begin
                cnt_q      <= term ? '0 : cnt_q + IDX_WIDTH'(1);
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
                if (term) begin
                    class_idx_q <= best_idx_d;
                    max_score_q <= best_d;
                    frame_err_q <= err;
                end
            end
            if (handshake) img_count_q <= img_count_q + CNT_WIDTH'(1);
        end
    end

    assign class_idx = class_idx_q;
    assign max_score = max_score_q;
    assign frame_err = frame_err_q;
    assign img_count = img_count_q;

`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_WIDTH-1:0] sec_q, sec_d;
    logic        [IDX_WIDTH-1:0]  sec_idx_q, sec_idx_d;
    logic        [IDX_WIDTH-1:0]  second_idx_q;
    logic        [DATA_WIDTH:0]   margin_q, margin_d;

    // A displaced best drops into second; otherwise the beat competes for second.
    always_comb begin
        sec_d     = sec_q;
        sec_idx_d = sec_idx_q;
        if (first) begin
            sec_d     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sec_idx_d = '0;
        end else if (gt) begin
            sec_d     = best_q;
            sec_idx_d = best_idx_q;
        end else if (in_data > sec_q) begin
            sec_d     = in_data;
            sec_idx_d = cnt_q;
        end
        margin_d = first ? '0
                         : {best_d[DATA_WIDTH-1], best_d} - {sec_d[DATA_WIDTH-1], sec_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q        <= '0;
            sec_idx_q    <= '0;
            second_idx_q <= '0;
            margin_q     <= '0;
        end else if (beat) begin
            sec_q     <= sec_d;
            sec_idx_q <= sec_idx_d;
            if (term) begin
                second_idx_q <= sec_idx_d;
                margin_q     <= margin_d;
            end
        end
    end

    assign second_idx = second_idx_q;
    assign margin     = margin_q;
`endif

endmodule

// File: tb/tb_layer5_argmax.sv
// tb/tb_layer5_argmax.sv - randomized and directed bench for layer5_argmax against a frame-level model
module tb_layer5_argmax;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  class_idx;
    logic [31:0] max_score;
    logic        frame_err;
    logic [15:0] img_count;
`ifdef ARGMAX_TOP2_EN
    logic [3:0]  second_idx;
    logic [32:0] margin;
`endif

    layer5_argmax dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .max_score (max_score),
        .frame_err (frame_err),
`ifdef ARGMAX_TOP2_EN
        .second_idx(second_idx),
        .margin    (margin),
`endif
        .img_count (img_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fv[16];
    int fn;
    bit flast;
    int exp_cnt = 0;

    task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: first strict maximum wins; a frame is well formed only
    // when it has exactly N beats with the marker on the last one.
    task model(output int eidx, output int escore, output bit eerr);
        eidx   = 0;
        escore = fv[0];
        for (int i = 1; i < fn; i++)
            if (fv[i] > escore) begin
                escore = fv[i];
                eidx   = i;
            end
        eerr = !(fn == N && flast);
    endtask

    task send_beat(input int v, input bit last);
        bit ok;
        ok       = 1'b0;
        valid_in = 1'b1;
        in_data  = v;
        in_last  = last;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        in_last  = 1'b0;
        if (!ok) check("beat_accept_timeout", 0, 1);
    endtask

    task run_frame(input bit bp);
        int eidx, escore;
        bit eerr;
        model(eidx, escore, eerr);
        out_ready = !bp;
        for (int i = 0; i < fn; i++) send_beat(fv[i], flast && (i == fn - 1));
        check("latency_out_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("class_idx", class_idx, eidx);
        check("max_score", max_score, $unsigned(escore));
        check("frame_err", frame_err, eerr);
        if (bp) begin
            valid_in = 1'b1;
            in_data  = 32'd1000;
            in_last  = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check("bp_out_valid", out_valid, 1);
                check("bp_in_ready", in_ready, 0);
                check("bp_class_idx", class_idx, eidx);
                check("bp_max_score", max_score, $unsigned(escore));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            valid_in  = 1'b0;
            in_last   = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("img_count", img_count, exp_cnt);
        check("retain_class_idx", class_idx, eidx);
    endtask

    task load(input int n, input bit last, input int v0, input int v1, input int v2,
              input int v3, input int v4, input int v5, input int v6, input int v7,
              input int v8, input int v9);
        fn = n; flast = last;
        fv[0] = v0; fv[1] = v1; fv[2] = v2; fv[3] = v3; fv[4] = v4;
        fv[5] = v5; fv[6] = v6; fv[7] = v7; fv[8] = v8; fv[9] = v9;
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_class_idx", class_idx, 0);
        check("rst_max_score", max_score, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_img_count", img_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        load(10, 1, 5, -3, 12, 7, 0, 1, 2, 40, -8, 9);             run_frame(0);
        load(10, 1, 1, 3, 20, 4, 20, 0, 0, 0, 0, 0);               run_frame(0);
        load(10, 1, -100, -7, -50, -7, -9, -200, -8, -7, -30, -11); run_frame(0);
        load(10, 1, 32'h8000_0000, -1, -1, -1, -1, -1, -1, -1, -1, -1); run_frame(0);
        load(5, 1, 0, 0, 0, 9, 2, 0, 0, 0, 0, 0);                  run_frame(0);
        load(10, 0, 3, 1, 4, 1, 5, 9, 2, 6, 5, 3);                 run_frame(0);
        load(1, 1, -42, 0, 0, 0, 0, 0, 0, 0, 0, 0);                run_frame(0);
        load(10, 1, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16);          run_frame(1);
        load(10, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3);                 run_frame(0);

        for (int f = 0; f < 24; f++) begin
            fn    = $urandom_range(1, N);
            flast = (fn < N) ? 1'b1 : 1'b0;
            if (fn == N) flast = $urandom_range(0, 1);
            for (int i = 0; i < fn; i++)
                fv[i] = (f % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 6)) - 3;
            run_frame(f % 7 == 3);
        end

        load(10, 1, 1, 3, 20, 4, 20, 0, 0, 0, 0, 0);
        run_frame(0);
        for (int i = 0; i < 7; i++) send_beat(5000 + i, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_class_idx", class_idx, 0);
        check("midrst_max_score", max_score, 0);
        check("midrst_img_count", img_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1);
        load(10, 1, -5, 6, 100, 3, 99, 100, -1, 0, 50, 7);
        run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
